// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer stage and sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              EN;
  logic              WR;
  logic              RD;
  logic [DATA_W-1:0] dataIN;
  logic [DATA_W-1:0] dataOut;
  logic              VALID;
  logic              EMPTY;
  logic              FULL;
  logic              ALMOST_EMPTY;
  logic              ALMOST_FULL;
  logic [ADDR_W:0]   COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output EN, WR, RD, dataIN,
    input  dataOut, VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
           COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  EN, WR, RD, dataIN,
    output dataOut, VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
           COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input logic               CLK,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int unsigned     ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf;
  logic              udf;

  always_comb begin
    empty  = (count == '0);
    full   = (count == DEPTH_C);
    rd_acc = bus.EN & bus.RD & ~empty;
    // A pop on a full FIFO frees the slot the write lands in.
    wr_acc = bus.EN & bus.WR & (~full | rd_acc);
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.dataIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.EN & bus.WR & full & ~rd_acc) begin
        ovf <= 1'b1;
      end
      if (bus.EN & bus.RD & empty) begin
        udf <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dataOut = empty ? '0 : mem[rd_ptr];
  assign bus.VALID   = ~empty;
`else
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.VALID   = valid_q;
`endif

  assign bus.COUNT        = count;
  assign bus.EMPTY        = empty;
  assign bus.FULL         = full;
  assign bus.ALMOST_EMPTY = (count <= AE_C);
  assign bus.ALMOST_FULL  = (count >= AF_C);
  assign bus.OVERFLOW     = ovf;
  assign bus.UNDERFLOW    = udf;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO: the next-generation replacement for the team's fixed 32x8 buffer.
- Generalised data width and power-of-two depth.
- Adds exact occupancy count, programmable almost-full/almost-empty flags, registered read with valid strobe, and sticky overflow/underflow error flags.
- Single clock domain; sits between producer/consumer datapath stages wherever rate smoothing is needed.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 8, number of entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)
AF_THRESH, DEPTH-2, ALMOST_FULL asserted when COUNT >= AF_THRESH
AE_THRESH, 1, ALMOST_EMPTY asserted when COUNT <= AE_THRESH

Ports:
CLK  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
EN  input  1  block enable; 0 freezes FIFO state
WR  input  1  write request
RD  input  1  read request
dataIN  input  DATA_W  write data
dataOut  output  DATA_W  read data
VALID  output  1  dataOut holds a newly popped word
EMPTY  output  1  COUNT == 0
FULL  output  1  COUNT == DEPTH
ALMOST_EMPTY  output  1  COUNT <= AE_THRESH
ALMOST_FULL  output  1  COUNT >= AF_THRESH
COUNT  output  ADDR_W+1  current occupancy, 0..DEPTH
OVERFLOW  output  1  sticky: write attempted while full and not popped
UNDERFLOW  output  1  sticky: read attempted while empty

Behaviour:
- Reset: synchronous on CLK when rst=1; overrides EN.
  - Reset values: wr_ptr=0, rd_ptr=0, COUNT=0, dataOut=0, VALID=0, OVERFLOW=0, UNDERFLOW=0.
  - Reset flag values: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; the next cycle behaves as a fresh FIFO.
- EN=0: WR and RD are ignored. Pointers, COUNT, memory, dataOut and sticky flags hold. VALID goes to 0 at the next edge.
- Write accept (wr_acc) = EN & WR & (~FULL | rd_acc). On accept, mem[wr_ptr] <= dataIN and wr_ptr increments.
- Read accept (rd_acc) = EN & RD & ~EMPTY. On accept, dataOut <= mem[rd_ptr], rd_ptr increments, and VALID=1 at the same edge.
  - Read latency is one cycle from the RD edge.
  - VALID=0 on any edge without rd_acc; dataOut holds its last value.
- Pointers are ADDR_W bits wide and wrap DEPTH-1 -> 0 naturally. There is no separate wrap logic.
- COUNT update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
  - never exceeds DEPTH, never goes below 0
- All flags are combinational decodes of COUNT, valid in the same cycle as COUNT.
- Simultaneous RD & WR:
  - Empty: write accepted, read rejected (UNDERFLOW set), COUNT -> 1.
  - Full: both accepted; the written slot is the one freed. COUNT stays DEPTH; FULL stays 1.
  - Otherwise: both accepted, COUNT unchanged.
- Error flags:
  - OVERFLOW <= 1 when EN & WR & FULL & ~rd_acc; the write is dropped and memory is unchanged.
  - UNDERFLOW <= 1 when EN & RD & EMPTY.
  - Both are cleared only by rst.

Optional Feature:
Macro: FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - dataOut = mem[rd_ptr] combinationally; VALID = ~EMPTY.
  - RD acts as an acknowledge that pops the head word. rd_acc is unchanged.
  - A word written at edge N is visible on dataOut with VALID=1 after edge N.
  - dataOut holds the reset value 0 only while EMPTY; it is don't-care when VALID=0.
- Undefined: registered-read behaviour described above.

Test Plan:
Defaults (DATA_W=32, DEPTH=8, AF_THRESH=6, AE_THRESH=1).
1. Basic order: rst, then write 0xA0..0xA7 on 8 consecutive cycles -> FULL=1, COUNT=8, ALMOST_FULL from COUNT=6. Then read 8 cycles -> dataOut 0xA0..0xA7 each one cycle after RD with VALID=1, then EMPTY=1, COUNT=0.
2. Wrap-around: write 5, read 5, write 6 (0xB0..0xB5), read 6 -> data order preserved across the pointer wrap; COUNT peaks at 6; UNDERFLOW/OVERFLOW stay 0.
3. Full boundary: fill to 8, then WR alone with 0xDEAD -> OVERFLOW=1, COUNT=8, 0xDEAD is never read. Then RD & WR (0xBEEF) together -> COUNT=8, and 0xBEEF is the last word read.
4. Empty boundary: from empty, RD -> UNDERFLOW=1, VALID stays 0. RD & WR (0x55) together -> COUNT=1, then RD -> dataOut=0x55, VALID=1.
5. Enable/reset: with 3 words stored, EN=0 with WR & RD held 4 cycles -> COUNT=3, no VALID. Then assert rst with EN=0 -> COUNT=0, EMPTY=1, sticky flags cleared.
6. FWFT build (FIFO_FWFT_EN): write 0x11 into empty -> after that edge VALID=1, dataOut=0x11 with no RD. RD -> next head word or VALID=0.
